sys_bus_arbiter: RTL and testbench

- Shares the single system memory bus between the core instruction-fetch port and the data load/store port.
- Performs region decode internally with the system memory map:
  - PFM: addr[31:28]==0
  - SFR: addr[31:12] all ones and addr[11]==1
  - IO: addr[31:12] all ones and addr[11]==0
  - UNDEF: addr[31:30]==2'b11 and not SFR/IO
  - DFM: everything else
- Drives exactly one region enable for the granted access and inserts per-region wait states.
- Returns a single-cycle ack with read data, or an error, to the owning requester.

---
 rtl/sys_bus_pkg.sv | 26 ++
 rtl/sys_bus_arbiter_if.sv | 39 +++
 rtl/bus_rr_arb.sv | 34 +++
 rtl/sys_bus_arbiter.sv | 145 ++++++++++++++
 tb/tb_sys_bus_arbiter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/sys_bus_pkg.sv
// Shared types, address-map constants and region decode for the system bus arbiter.
package sys_bus_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP, ST_ERR} state_e;
  typedef enum logic [2:0] {RGN_PFM, RGN_DFM, RGN_SFR, RGN_IO, RGN_UNDEF} region_e;
  typedef enum logic {REQ_FETCH = 1'b0, REQ_DATA = 1'b1} req_id_e;

  localparam int          NIB_LSB     = 28;
  localparam logic [3:0]  PFM_NIB     = 4'h0;
  localparam int          HI2_LSB     = 30;
  localparam logic [1:0]  UNDEF_HI2   = 2'b11;
  localparam int          PERIPH_LSB  = 12;
  localparam logic [19:0] PERIPH_PAGE = 20'hFFFFF;
  localparam int          SFR_BIT     = 11;

  // Peripheral page is tested first: it also lies inside the UNDEF top quarter.
  function automatic region_e decode_region(input logic [31:0] addr);
    region_e r;
    if (addr[31:PERIPH_LSB] == PERIPH_PAGE) r = addr[SFR_BIT] ? RGN_SFR : RGN_IO;
    else if (addr[31:NIB_LSB] == PFM_NIB)   r = RGN_PFM;
    else if (addr[31:HI2_LSB] == UNDEF_HI2) r = RGN_UNDEF;
    else                                    r = RGN_DFM;
    return r;
  endfunction

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Requester handshakes plus the shared memory bus; slave = arbiter view, master = environment view.
interface sys_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_err;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic        bus_en_pfm;
  logic        bus_en_dfm;
  logic        bus_en_sfr;
  logic        bus_en_io;
  logic [31:0] bus_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, bus_rdata,
    output if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
    output bus_addr, bus_wdata, bus_we, bus_be,
    output bus_en_pfm, bus_en_dfm, bus_en_sfr, bus_en_io
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, bus_rdata,
    input  if_ack, if_err, if_rdata, d_ack, d_err, d_rdata,
    input  bus_addr, bus_wdata, bus_we, bus_be,
    input  bus_en_pfm, bus_en_dfm, bus_en_sfr, bus_en_io
  );
endinterface

// File: rtl/bus_rr_arb.sv
// Two-requester round-robin: on contention grants the side opposite the last winner.
module bus_rr_arb
  import sys_bus_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_fetch_i,
  input  logic    req_data_i,
  input  logic    take_i,
  output logic    gnt_valid_o,
  output req_id_e gnt_id_o
);

  req_id_e last_gnt_q;

  always_comb begin
    gnt_valid_o = req_fetch_i | req_data_i;
    if (req_fetch_i && req_data_i)
      gnt_id_o = (last_gnt_q == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
    else if (req_data_i)
      gnt_id_o = REQ_DATA;
    else
      gnt_id_o = REQ_FETCH;
  end

  // Reset value FETCH makes the first contention after reset go to data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_gnt_q <= REQ_FETCH;
    else if (take_i && gnt_valid_o)
      last_gnt_q <= gnt_id_o;
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Shares the system memory bus between fetch and data ports with region decode and wait states.
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int unsigned PFM_WS    = 2,
  parameter int unsigned DFM_WS    = 0,
  parameter int unsigned PERIPH_WS = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  sys_bus_arbiter_if.slave   bus_if
);

  state_e      state_q;
  req_id_e     owner_q;
  logic [3:0]  cnt_q;
  logic [3:0]  en_q;  // {io, sfr, dfm, pfm}
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic        bus_we_q;
  logic [3:0]  bus_be_q;
  logic        if_ack_q, if_err_q, d_ack_q, d_err_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  logic        gnt_valid;
  req_id_e     gnt_id;
  logic [31:0] addr_d, wdata_d;
  logic        we_d, legal_d;
  logic [3:0]  be_d, en_d, ws_d;
  region_e     region_d;

  bus_rr_arb u_rr_arb (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .req_fetch_i (bus_if.if_req),
    .req_data_i  (bus_if.d_req),
    .take_i      (state_q == ST_IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_comb begin
    addr_d  = bus_if.if_addr;
    wdata_d = '0;
    we_d    = 1'b0;
    be_d    = 4'hF;
    if (gnt_id == REQ_DATA) begin
      addr_d  = bus_if.d_addr;
      wdata_d = bus_if.d_wdata;
      we_d    = bus_if.d_we;
      be_d    = bus_if.d_be;
    end
    region_d = decode_region(addr_d);
    en_d     = 4'b0000;
    ws_d     = 4'd0;
    case (region_d)
      RGN_PFM: begin en_d = 4'b0001; ws_d = 4'(PFM_WS);    end
      RGN_DFM: begin en_d = 4'b0010; ws_d = 4'(DFM_WS);    end
      RGN_SFR: begin en_d = 4'b0100; ws_d = 4'(PERIPH_WS); end
      RGN_IO:  begin en_d = 4'b1000; ws_d = 4'(PERIPH_WS); end
      default: begin en_d = 4'b0000; ws_d = 4'd0;          end
    endcase
    legal_d = (region_d != RGN_UNDEF) && !((region_d == RGN_PFM) && we_d);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_FETCH;
      cnt_q       <= '0;
      en_q        <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      if_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (gnt_valid) begin
          owner_q     <= gnt_id;
          bus_addr_q  <= addr_d;
          bus_wdata_q <= wdata_d;
          bus_be_q    <= be_d;
          if (legal_d) begin
            bus_we_q <= we_d;
            en_q     <= en_d;
            cnt_q    <= ws_d;
            state_q  <= ST_ACCESS;
          end else begin
            bus_we_q <= 1'b0;
            if_ack_q <= (gnt_id == REQ_FETCH);
            if_err_q <= (gnt_id == REQ_FETCH);
            d_ack_q  <= (gnt_id == REQ_DATA);
            d_err_q  <= (gnt_id == REQ_DATA);
            state_q  <= ST_ERR;
          end
        end
        ST_ACCESS: if (cnt_q == 4'd0) begin
          en_q     <= '0;
          bus_we_q <= 1'b0;
          state_q  <= ST_RESP;
          if (owner_q == REQ_FETCH) begin
            if_ack_q   <= 1'b1;
            if_rdata_q <= bus_if.bus_rdata;
          end else begin
            d_ack_q   <= 1'b1;
            d_rdata_q <= bus_we_q ? 32'h0 : bus_if.bus_rdata;
          end
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        ST_RESP, ST_ERR: begin
          if_ack_q   <= 1'b0;
          if_err_q   <= 1'b0;
          if_rdata_q <= '0;
          d_ack_q    <= 1'b0;
          d_err_q    <= 1'b0;
          d_rdata_q  <= '0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_if.if_ack     = if_ack_q;
  assign bus_if.if_err     = if_err_q;
  assign bus_if.if_rdata   = if_rdata_q;
  assign bus_if.d_ack      = d_ack_q;
  assign bus_if.d_err      = d_err_q;
  assign bus_if.d_rdata    = d_rdata_q;
  assign bus_if.bus_addr   = bus_addr_q;
  assign bus_if.bus_wdata  = bus_wdata_q;
  assign bus_if.bus_we     = bus_we_q;
  assign bus_if.bus_be     = bus_be_q;
  assign bus_if.bus_en_pfm = en_q[0];
  assign bus_if.bus_en_dfm = en_q[1];
  assign bus_if.bus_en_sfr = en_q[2];
  assign bus_if.bus_en_io  = en_q[3];

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter: cycle-exact checks of grants, enables, acks and reset.
module tb_sys_bus_arbiter;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  sys_bus_arbiter_if bif ();

  sys_bus_arbiter #(.PFM_WS(2), .DFM_WS(0), .PERIPH_WS(1)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus_if    (bif)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{bif.if_ack, bif.if_err, bif.if_rdata, bif.d_ack, bif.d_err, bif.d_rdata,
             bif.bus_addr, bif.bus_wdata, bif.bus_we, bif.bus_be,
             bif.bus_en_pfm, bif.bus_en_dfm, bif.bus_en_sfr, bif.bus_en_io};
  endfunction

  function automatic logic any_en();
    return bif.bus_en_pfm | bif.bus_en_dfm | bif.bus_en_sfr | bif.bus_en_io;
  endfunction

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    bif.if_req = 1'b0; bif.if_addr = 32'h0;
    bif.d_req = 1'b0; bif.d_we = 1'b0; bif.d_be = 4'h0;
    bif.d_addr = 32'h0; bif.d_wdata = 32'h0; bif.bus_rdata = 32'h0;
    sys_rst_n = 1'b0;
    tick();
    tick();
    chk1("reset_outputs_zero", any_out(), 1'b0);
    sys_rst_n = 1'b1;

    // Fetch-only PFM read, 2 wait states
    bif.if_req = 1'b1; bif.if_addr = 32'h0000_0100; bif.bus_rdata = 32'hDEAD_BEEF;
    tick();
    chk32("pfm_bus_addr", bif.bus_addr, 32'h0000_0100);
    chk32("pfm_bus_be", {28'h0, bif.bus_be}, 32'h0000_000F);
    chk1("pfm_bus_we", bif.bus_we, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) tick();
      $display("fetch pfm cycle %0d en_pfm=%b if_ack=%b", i, bif.bus_en_pfm, bif.if_ack);
      chk1("pfm_en_window", bif.bus_en_pfm, 1'b1);
      chk1("pfm_no_early_ack", bif.if_ack, 1'b0);
    end
    tick();
    $display("fetch pfm ack=%b rdata=%h err=%b", bif.if_ack, bif.if_rdata, bif.if_err);
    chk1("pfm_ack", bif.if_ack, 1'b1);
    chk32("pfm_rdata", bif.if_rdata, 32'hDEAD_BEEF);
    chk1("pfm_err", bif.if_err, 1'b0);
    chk1("pfm_en_off", bif.bus_en_pfm, 1'b0);
    chk1("pfm_no_dack", bif.d_ack, 1'b0);
    bif.if_req = 1'b0;
    tick();
    chk1("pfm_ack_single", bif.if_ack, 1'b0);
    chk32("pfm_rdata_cleared", bif.if_rdata, 32'h0);

    // Contention after reset: data first, then fetch, then data again
    do_reset();
    bif.if_req = 1'b1; bif.if_addr = 32'h0000_0000;
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_be = 4'hF; bif.d_addr = 32'h2000_0000;
    bif.bus_rdata = 32'h1111_2222;
    tick();
    chk1("rr1_en_dfm", bif.bus_en_dfm, 1'b1);
    chk1("rr1_en_pfm", bif.bus_en_pfm, 1'b0);
    chk32("rr1_bus_addr", bif.bus_addr, 32'h2000_0000);
    tick();
    $display("contention 1 d_ack=%b d_rdata=%h if_ack=%b", bif.d_ack, bif.d_rdata, bif.if_ack);
    chk1("rr1_dack", bif.d_ack, 1'b1);
    chk32("rr1_drdata", bif.d_rdata, 32'h1111_2222);
    chk1("rr1_no_iack", bif.if_ack, 1'b0);
    chk32("rr1_if_rdata_zero", bif.if_rdata, 32'h0);
    bif.d_req = 1'b0;
    tick();
    chk1("rr_idle_gap_en", any_en(), 1'b0);
    chk1("rr_idle_gap_dack", bif.d_ack, 1'b0);
    tick();
    chk1("rr2_en_pfm", bif.bus_en_pfm, 1'b1);
    chk32("rr2_bus_addr", bif.bus_addr, 32'h0000_0000);
    bif.d_req = 1'b1; bif.d_addr = 32'h2000_0004; bif.bus_rdata = 32'h3333_4444;
    tick();
    tick();
    tick();
    $display("contention 2 if_ack=%b if_rdata=%h d_ack=%b", bif.if_ack, bif.if_rdata, bif.d_ack);
    chk1("rr2_iack", bif.if_ack, 1'b1);
    chk32("rr2_irdata", bif.if_rdata, 32'h3333_4444);
    chk1("rr2_no_dack", bif.d_ack, 1'b0);
    tick();
    tick();
    chk1("rr3_en_dfm", bif.bus_en_dfm, 1'b1);
    chk1("rr3_en_pfm", bif.bus_en_pfm, 1'b0);
    chk32("rr3_bus_addr", bif.bus_addr, 32'h2000_0004);
    tick();
    $display("contention 3 d_ack=%b", bif.d_ack);
    chk1("rr3_dack", bif.d_ack, 1'b1);
    bif.d_req = 1'b0;
    tick();
    tick();
    chk1("rr4_en_pfm", bif.bus_en_pfm, 1'b1);
    bif.if_req = 1'b0;
    tick();
    tick();
    tick();
    $display("dropped fetch if_ack=%b", bif.if_ack);
    chk1("dropped_req_still_acks", bif.if_ack, 1'b1);
    tick();

    // SFR write, 1 wait state
    bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_be = 4'b0011;
    bif.d_addr = 32'hFFFF_F804; bif.d_wdata = 32'h1234_5678; bif.bus_rdata = 32'hAAAA_5555;
    tick();
    chk1("sfr_en1", bif.bus_en_sfr, 1'b1);
    chk1("sfr_we1", bif.bus_we, 1'b1);
    chk32("sfr_be", {28'h0, bif.bus_be}, 32'h0000_0003);
    chk32("sfr_wdata", bif.bus_wdata, 32'h1234_5678);
    tick();
    chk1("sfr_en2", bif.bus_en_sfr, 1'b1);
    chk1("sfr_we2", bif.bus_we, 1'b1);
    chk32("sfr_wdata2", bif.bus_wdata, 32'h1234_5678);
    chk1("sfr_no_early_ack", bif.d_ack, 1'b0);
    tick();
    $display("sfr write d_ack=%b d_err=%b d_rdata=%h", bif.d_ack, bif.d_err, bif.d_rdata);
    chk1("sfr_dack", bif.d_ack, 1'b1);
    chk1("sfr_derr", bif.d_err, 1'b0);
    chk32("sfr_write_rdata_zero", bif.d_rdata, 32'h0);
    chk1("sfr_en_off", bif.bus_en_sfr, 1'b0);
    chk1("sfr_we_off", bif.bus_we, 1'b0);
    bif.d_req = 1'b0; bif.d_we = 1'b0;
    tick();

    // UNDEF read and PFM write both error at T+1
    bif.d_req = 1'b1; bif.d_addr = 32'hC000_0000; bif.bus_rdata = 32'h7777_8888;
    tick();
    $display("undef d_ack=%b d_err=%b", bif.d_ack, bif.d_err);
    chk1("undef_dack", bif.d_ack, 1'b1);
    chk1("undef_derr", bif.d_err, 1'b1);
    chk32("undef_rdata", bif.d_rdata, 32'h0);
    chk1("undef_no_en", any_en(), 1'b0);
    bif.d_req = 1'b0;
    tick();
    chk1("undef_ack_single", bif.d_ack, 1'b0);
    chk1("undef_err_single", bif.d_err, 1'b0);
    bif.d_req = 1'b1; bif.d_we = 1'b1; bif.d_addr = 32'h0000_0040; bif.d_wdata = 32'h5A5A_5A5A;
    tick();
    $display("pfm write d_ack=%b d_err=%b", bif.d_ack, bif.d_err);
    chk1("pfmwr_dack", bif.d_ack, 1'b1);
    chk1("pfmwr_derr", bif.d_err, 1'b1);
    chk1("pfmwr_no_en", any_en(), 1'b0);
    chk1("pfmwr_no_we", bif.bus_we, 1'b0);
    bif.d_req = 1'b0; bif.d_we = 1'b0;
    tick();

    // IO read interrupted by reset
    bif.d_req = 1'b1; bif.d_addr = 32'hFFFF_F000; bif.bus_rdata = 32'h5555_6666;
    tick();
    chk1("io_en", bif.bus_en_io, 1'b1);
    #2 sys_rst_n = 1'b0;
    #1;
    $display("reset mid access outputs_nonzero=%b", any_out());
    chk1("midreset_outputs_zero", any_out(), 1'b0);
    bif.d_req = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("post_reset_no_dack", bif.d_ack, 1'b0);
      chk1("post_reset_no_en", any_en(), 1'b0);
    end
    bif.if_req = 1'b1; bif.if_addr = 32'h0000_0000;
    bif.d_req = 1'b1; bif.d_addr = 32'h2000_0040; bif.bus_rdata = 32'h9999_0000;
    tick();
    chk1("post_reset_data_first", bif.bus_en_dfm, 1'b1);
    chk1("post_reset_pfm_wait", bif.bus_en_pfm, 1'b0);
    tick();
    chk1("post_reset_dack", bif.d_ack, 1'b1);
    chk32("post_reset_drdata", bif.d_rdata, 32'h9999_0000);
    chk1("post_reset_no_iack", bif.if_ack, 1'b0);
    bif.d_req = 1'b0; bif.if_req = 1'b0;
    tick();
    tick();

    // Continuous fetch: one ack every 5 cycles
    bif.if_req = 1'b1; bif.if_addr = 32'h0000_0010; bif.bus_rdata = 32'hCAFE_0010;
    for (int t = 1; t <= 20; t++) begin
      tick();
      $display("stream cycle %0d if_ack=%b d_ack=%b", t, bif.if_ack, bif.d_ack);
      chk1("stream_iack", bif.if_ack, (t % 5) == 4);
      chk1("stream_no_dack", bif.d_ack, 1'b0);
      if ((t % 5) == 4) chk32("stream_rdata", bif.if_rdata, 32'hCAFE_0010);
    end
    bif.if_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
